shifter_pipe: RTL and testbench

SHIFTER_PIPE -- requirements
Module: shifter_pipe

---
 rtl/shifter_pipe.sv | 111 +++++++++++
 tb/tb_shifter_pipe.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_pipe.sv
// Two-stage pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready flow control.
// Stage 1 applies the coarse shift (upper shamt bits); stage 2 applies the fine shift.
module shifter_pipe #(
    parameter  int unsigned WIDTH   = 32,
    localparam int unsigned SHAMT_W = $clog2(WIDTH),
    localparam int unsigned SPLIT   = SHAMT_W / 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero
);

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    // Shifts by WIDTH yield zero, which makes the fill/wrap terms vanish for amt == 0.
    function automatic logic [WIDTH-1:0] shift_op(
        input op_t                op,
        input logic               sign,
        input logic [WIDTH-1:0]   d,
        input logic [SHAMT_W-1:0] amt
    );
        logic [WIDTH-1:0] r;
        r = d;
        unique case (op)
            OP_SLL: r = d << amt;
            OP_SRL: r = d >> amt;
            OP_SRA: r = (d >> amt) | ({WIDTH{sign}} << (WIDTH - 32'(amt)));
            OP_ROR: r = (d >> amt) | (d << (WIDTH - 32'(amt)));
        endcase
        return r;
    endfunction

    logic               s1_valid;
    logic [WIDTH-1:0]   s1_data;
    op_t                s1_op;
    logic               s1_sign;
    logic [SPLIT-1:0]   s1_lo;

    logic               s2_valid;
    logic [WIDTH-1:0]   s2_data;
    logic               s2_zero;

    logic               s1_adv;
    logic               s2_adv;
    logic               take_in;
    logic [SHAMT_W-1:0] s1_amt;
    logic [WIDTH-1:0]   s1_next;
    logic [WIDTH-1:0]   s2_next;

    always_comb begin
        s2_adv   = !s2_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = s1_adv && !flush;
        take_in  = in_valid && in_ready;
        s1_amt   = {in_shamt[SHAMT_W-1:SPLIT], {SPLIT{1'b0}}};
        s1_next  = shift_op(op_t'(in_op), in_data[WIDTH-1], in_data, s1_amt);
        s2_next  = shift_op(s1_op, s1_sign, s1_data, SHAMT_W'(s1_lo));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_adv) s1_valid <= in_valid;
            if (s2_adv) s2_valid <= s1_valid;
        end
    end

    // Operand MSB is carried separately so SRA fill never depends on the partial result.
    always_ff @(posedge clk) begin
        if (take_in) begin
            s1_data <= s1_next;
            s1_op   <= op_t'(in_op);
            s1_sign <= in_data[WIDTH-1];
            s1_lo   <= in_shamt[SPLIT-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_data <= '0;
            s2_zero <= 1'b1;
        end else if (!flush && s2_adv && s1_valid) begin
            s2_data <= s2_next;
            s2_zero <= (s2_next == '0);
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_zero  = s2_zero;

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed and randomized checks of shifter_pipe against a queue-based reference
// model that computes each result directly from the shift-mode rules.
module tb_shifter_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_zero;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int taken    = 0;
    bit acc;
    bit held_valid = 0;
    logic [31:0] held_data;

    typedef struct {
        logic [31:0] val;
        int          stamp;
    } ent_t;
    ent_t q[$];

    shifter_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input int s);
        logic [31:0] r;
        r = d;
        case (op)
            2'd0: r = d << s;
            2'd1: r = d >> s;
            2'd2: for (int i = 0; i < s; i++) r = {d[31], r[31:1]};
            default: for (int i = 0; i < s; i++) r = {r[0], r[31:1]};
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model, then advance the model across the edge.
    task automatic tick();
        bit   exp_rdy;
        bit   exp_ov;
        bit   take;
        ent_t e;
        #1;
        exp_rdy = !flush && !(q.size() == 2 && !out_ready);
        exp_ov  = (q.size() > 0) && (cyc >= q[0].stamp + 1);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        if (held_valid) chk("stall_hold", out_data, held_data);
        take = exp_ov && out_ready;
        acc  = in_valid && exp_rdy;
        if (take) begin
            chk("out_data", out_data, q[0].val);
            chk("out_zero", 32'(out_zero), 32'(q[0].val == 0));
        end
        held_valid = exp_ov && !out_ready && !flush;
        held_data  = exp_ov ? q[0].val : 32'h0;
        e.val   = ref_shift(in_op, in_data, int'(in_shamt));
        e.stamp = 0;
        @(posedge clk);
        cyc++;
        if (flush) begin
            q.delete();
        end else begin
            if (take) begin
                void'(q.pop_front());
                taken++;
            end
            if (acc) begin
                e.stamp = cyc;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic set_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
        in_op    = op;
        in_data  = d;
        in_shamt = s;
    endtask

    // Single op on an empty pipe: result must be visible after the acceptance edge plus one.
    task automatic single(input string tag, input logic [1:0] op, input logic [31:0] d,
                          input logic [4:0] s, input logic [31:0] expv);
        flush     = 0;
        out_ready = 1;
        in_valid  = 1;
        set_op(op, d, s);
        tick();
        in_valid = 0;
        set_op(2'($urandom), $urandom, 5'($urandom));
        tick();
        #1;
        chk(tag, out_data, expv);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_zero"}, 32'(out_zero), 32'(expv == 0));
        tick();
    endtask

    task automatic mid_reset();
        #2 rst_n = 0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_zero", 32'(out_zero), 32'd1);
        q.delete();
        held_valid = 0;
        @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);
    endtask

    initial begin
        int n0;
        rst_n     = 0;
        flush     = 0;
        in_valid  = 0;
        out_ready = 0;
        set_op(2'd0, 32'h0, 5'd0);
        @(negedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_out_zero", 32'(out_zero), 32'd1);
        #1 rst_n = 1;
        @(negedge clk);

        single("sll_1_31", 2'd0, 32'h00000001, 5'd31, 32'h80000000);
        single("sll_msb_1", 2'd0, 32'h80000000, 5'd1, 32'h00000000);
        single("sra_4", 2'd2, 32'h80000000, 5'd4, 32'hF8000000);
        single("srl_4", 2'd1, 32'h80000000, 5'd4, 32'h08000000);
        single("srl_16", 2'd1, 32'h12345678, 5'd16, 32'h00001234);
        single("ror_4", 2'd3, 32'h000000F1, 5'd4, 32'h1000000F);
        single("ror_0", 2'd3, 32'hDEADBEEF, 5'd0, 32'hDEADBEEF);
        single("sra_pos_7", 2'd2, 32'h40000000, 5'd7, 32'h00800000);

        // Back-to-back ops with a three-cycle output stall.
        n0        = taken;
        out_ready = 1;
        in_valid  = 1;
        set_op(2'd0, 32'h00000001, 5'd3);
        tick();
        set_op(2'd1, 32'h000000F0, 5'd4);
        tick();
        out_ready = 0;
        set_op(2'd3, 32'h00000001, 5'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_no_accept", 32'(acc), 32'd0);
        end
        out_ready = 1;
        for (int i = 0; i < 5 && !acc; i++) tick();
        chk("third_accepted", 32'(acc), 32'd1);
        in_valid = 0;
        for (int i = 0; i < 6; i++) tick();
        chk("stall_result_count", 32'(taken - n0), 32'd3);

        // Flush with two ops in flight and a third offered.
        in_valid = 1;
        set_op(2'd0, 32'h0000000F, 5'd8);
        tick();
        set_op(2'd1, 32'hFFFF0000, 5'd8);
        tick();
        set_op(2'd2, 32'hF0000000, 5'd2);
        flush = 1;
        tick();
        flush    = 0;
        in_valid = 0;
        #1 chk("flush_out_valid", 32'(out_valid), 32'd0);
        n0 = taken;
        for (int i = 0; i < 3; i++) tick();
        chk("flush_no_results", 32'(taken - n0), 32'd0);
        single("post_flush", 2'd2, 32'h80000001, 5'd31, 32'hFFFFFFFF);

        // Randomized traffic, with an asynchronous reset dropped into the middle.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                flush    = 0;
                in_valid = 0;
                mid_reset();
                tick();
                single("post_reset", 2'd1, 32'h12345678, 5'd16, 32'h00001234);
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 3))
                0:       set_op(2'($urandom), 32'h80000000, 5'($urandom));
                1:       set_op(2'($urandom), $urandom, 5'd0);
                default: set_op(2'($urandom), $urandom, 5'($urandom));
            endcase
            tick();
        end

        flush     = 0;
        in_valid  = 0;
        out_ready = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
